// File: rtl/semaforo_pkg.sv
// Shared types, default timings and lamp decoding
// for the two-way intersection signal controller.
package semaforo_pkg;

    typedef enum logic [2:0] {
        NS_VERDE   = 3'd0,
        NS_AMARELO = 3'd1,
        VERMELHO_1 = 3'd2,
        LO_VERDE   = 3'd3,
        LO_AMARELO = 3'd4,
        VERMELHO_2 = 3'd5
    } estado_t;

    localparam int T_MIN_VERDE_DEF = 4;
    localparam int T_MAX_VERDE_DEF = 10;
    localparam int T_AMARELO_DEF   = 2;
    localparam int T_VERMELHO_DEF  = 1;
    localparam int CNT_W_DEF       = 8;

    typedef struct packed {
        logic ns_verde;
        logic ns_amarelo;
        logic ns_vermelho;
        logic lo_verde;
        logic lo_amarelo;
        logic lo_vermelho;
    } lampadas_t;

    function automatic lampadas_t decodifica(estado_t e);
        lampadas_t l;
        l = '0;
        case (e)
            NS_VERDE:   l.ns_verde   = 1'b1;
            NS_AMARELO: l.ns_amarelo = 1'b1;
            LO_VERDE:   l.lo_verde   = 1'b1;
            LO_AMARELO: l.lo_amarelo = 1'b1;
            default:    l = '0;
        endcase
        // Red is simply "neither green nor yellow" for each direction.
        l.ns_vermelho = ~(l.ns_verde | l.ns_amarelo);
        l.lo_vermelho = ~(l.lo_verde | l.lo_amarelo);
        return l;
    endfunction

endpackage

// File: rtl/semaforo_temporizador.sv
// Tick-gated saturating phase counter, cleared on phase
// change, with a >= compare against a selectable limit.
module semaforo_temporizador #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             limpar,
    input  logic [CNT_W-1:0] limite,
    output logic [CNT_W-1:0] cnt,
    output logic             atingiu
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (limpar) begin
            cnt <= '0;
        end else if (tick && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign atingiu = (cnt >= limite);

endmodule

// File: rtl/semaforo_controlador.sv
// Timed phase sequencer for the NS / LO intersection:
// demand latches, phase FSM and Moore lamp outputs.
module semaforo_controlador
    import semaforo_pkg::*;
#(
    parameter int T_MIN_VERDE = T_MIN_VERDE_DEF,
    parameter int T_MAX_VERDE = T_MAX_VERDE_DEF,
    parameter int T_AMARELO   = T_AMARELO_DEF,
    parameter int T_VERMELHO  = T_VERMELHO_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       NS,
    output logic       LO,
    output logic       ns_amarelo,
    output logic       lo_amarelo,
    output logic       ns_vermelho,
    output logic       lo_vermelho,
    output logic [2:0] estado
);

    localparam logic [CNT_W-1:0] LIM_MIN = CNT_W'(T_MIN_VERDE - 1);
    localparam logic [CNT_W-1:0] LIM_MAX = CNT_W'(T_MAX_VERDE - 1);
    localparam logic [CNT_W-1:0] LIM_AM  = CNT_W'(T_AMARELO - 1);
    localparam logic [CNT_W-1:0] LIM_VM  = CNT_W'(T_VERMELHO - 1);

    estado_t          est;
    estado_t          proximo;
    logic             pend_ns;
    logic             pend_lo;
    logic             avanca;
    logic             atingiu;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limite;
    logic             dem_ns;
    logic             dem_lo;
    logic             no_max;
    lampadas_t        lamp;

    assign dem_ns = A | B;
    assign dem_lo = C | D;
    assign no_max = (cnt >= LIM_MAX);

    semaforo_temporizador #(
        .CNT_W(CNT_W)
    ) u_temporizador (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick),
        .limpar (avanca),
        .limite (limite),
        .cnt    (cnt),
        .atingiu(atingiu)
    );

    always_comb begin
        limite  = LIM_VM;
        proximo = NS_VERDE;
        avanca  = 1'b0;
        case (est)
            NS_VERDE: begin
                limite  = LIM_MIN;
                proximo = NS_AMARELO;
                avanca  = tick & atingiu & pend_lo & (~dem_ns | no_max);
            end
            NS_AMARELO: begin
                limite  = LIM_AM;
                proximo = VERMELHO_1;
                avanca  = tick & atingiu;
            end
            VERMELHO_1: begin
                proximo = LO_VERDE;
                avanca  = tick & atingiu;
            end
            LO_VERDE: begin
                limite  = LIM_MIN;
                proximo = LO_AMARELO;
                avanca  = tick & atingiu & pend_ns & (~dem_lo | no_max);
            end
            LO_AMARELO: begin
                limite  = LIM_AM;
                proximo = VERMELHO_2;
                avanca  = tick & atingiu;
            end
            VERMELHO_2: begin
                proximo = NS_VERDE;
                avanca  = tick & atingiu;
            end
            default: avanca = tick;
        endcase
    end

    // A new request seen outside its own green wins over the entry clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            est     <= NS_VERDE;
            pend_ns <= 1'b0;
            pend_lo <= 1'b0;
        end else begin
            if (avanca) begin
                est <= proximo;
            end
            if (dem_ns && (est != NS_VERDE)) begin
                pend_ns <= 1'b1;
            end else if (avanca && (proximo == NS_VERDE)) begin
                pend_ns <= 1'b0;
            end
            if (dem_lo && (est != LO_VERDE)) begin
                pend_lo <= 1'b1;
            end else if (avanca && (proximo == LO_VERDE)) begin
                pend_lo <= 1'b0;
            end
        end
    end

    assign lamp        = decodifica(est);
    assign NS          = lamp.ns_verde;
    assign ns_amarelo  = lamp.ns_amarelo;
    assign ns_vermelho = lamp.ns_vermelho;
    assign LO          = lamp.lo_verde;
    assign lo_amarelo  = lamp.lo_amarelo;
    assign lo_vermelho = lamp.lo_vermelho;
    assign estado      = est;

endmodule
